alu_pipe: RTL and testbench

//   Parametrised, registered EX-stage ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 95 +++++++++
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: opcode encodings, flag bit positions
// and the multiplier sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SLTU  = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;

  // Flag vector layout is {zero, neg, carry, ovf}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// signalling done combinationally on the final step so the caller can register it.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic [TAG_W-1:0] done_tag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] step_sum;

  // Bits shifted past WIDTH are dropped, so the product wraps modulo 2^WIDTH
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  assign busy     = (state_q == ST_MUL);
  assign done     = (state_q == ST_MUL) && (cnt_q == LAST);
  assign prod     = step_sum;
  assign done_tag = tag_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    tag_d    = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_MUL;
          cnt_d    = {SHW{1'b0}};
          acc_d    = {WIDTH{1'b0}};
          mcand_d  = a;
          mplier_d = b;
          tag_d    = tag;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = {SHW{1'b0}};
        end else begin
          cnt_d   = cnt_q + SHW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {SHW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {SHW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready on both sides; single-cycle ops complete
// in one edge, MUL is delegated to alu_mul_seq and completes WIDTH edges after accept.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             accept_s;
  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [TAG_W-1:0] mul_tag_s;
  logic [WIDTH+3:0] alu_out_s;

  // Returns {result, flags}; undefined opcodes yield all zeros including the zero flag
  function automatic logic [WIDTH+3:0] alu_eval(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [3:0]       f;
    logic [SHW-1:0]   sh;
    logic             known;
    sum   = {(WIDTH+1){1'b0}};
    r     = {WIDTH{1'b0}};
    f     = 4'b0000;
    sh    = b[SHW-1:0];
    known = 1'b1;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        r        = sum[WIDTH-1:0];
        f[FLG_C] = sum[WIDTH];
        f[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r        = a - b;
        f[FLG_C] = (a < b);
        f[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:   r = $unsigned($signed(a) >>> sh);
      OP_PASSB: r = b;
      default:  known = 1'b0;
    endcase
    f[FLG_Z] = known && (r == {WIDTH{1'b0}});
    f[FLG_N] = known && r[WIDTH-1];
    return {r, f};
  endfunction

  assign in_ready    = !mul_busy_s && (!out_valid_q || out_ready);
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (opcode == OP_MUL);
  assign alu_out_s   = alu_eval(opcode, A, B);

  alu_mul_seq #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start_s),
    .a        (A),
    .b        (B),
    .tag      (in_tag),
    .busy     (mul_busy_s),
    .done     (mul_done_s),
    .prod     (mul_prod_s),
    .done_tag (mul_tag_s)
  );

  // A MUL accept only happens when the output is empty or draining, so the drain
  // branch also covers out_valid falling on that edge
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_tag_d   = out_tag_q;
    if (accept_s && (opcode != OP_MUL)) begin
      out_valid_d = 1'b1;
      result_d    = alu_out_s[WIDTH+3:4];
      flags_d     = alu_out_s[3:0];
      out_tag_d   = in_tag;
    end else if (mul_done_s) begin
      out_valid_d = 1'b1;
      result_d    = mul_prod_s;
      flags_d     = {(mul_prod_s == {WIDTH{1'b0}}), mul_prod_s[WIDTH-1], 2'b00};
      out_tag_d   = mul_tag_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      out_tag_q   <= {TAG_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8, TAG_W=5.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] A;
  logic [7:0] B;
  logic [4:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic [4:0] out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(8), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .A         (A),
    .B         (B),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic offer(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    in_tag   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; A = 8'h00; B = 8'h00; in_tag = 5'd0;
    step(); step();
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== 18'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, 18'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL reset_ready: got %b want %b", {in_ready, out_valid}, 2'b10);
    end
  endtask

  task automatic test_add();
    logic [17:0] obs;
    offer(OP_ADD, 8'hFF, 8'h01, 5'd3);
    step();
    in_valid = 1'b0;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h00, 4'b1010, 5'd3}) begin
      n_bad++; $display("FAIL add_carry: got %h want %h", obs, {1'b1, 8'h00, 4'b1010, 5'd3});
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_drain: got %b want %b", out_valid, 1'b0);
    end
  endtask

  task automatic test_sub_sra();
    logic [17:0] obs;
    offer(OP_SUB, 8'h80, 8'h01, 5'd4);
    step();
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h7F, 4'b0001, 5'd4}) begin
      n_bad++; $display("FAIL sub_ovf: got %h want %h", obs, {1'b1, 8'h7F, 4'b0001, 5'd4});
    end
    offer(OP_SRA, 8'h90, 8'h02, 5'd5);
    step();
    in_valid = 1'b0;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'hE4, 4'b0100, 5'd5}) begin
      n_bad++; $display("FAIL sra_sign: got %h want %h", obs, {1'b1, 8'hE4, 4'b0100, 5'd5});
    end
    step();
  endtask

  task automatic test_mul();
    logic [17:0] obs;
    int n;
    offer(OP_MUL, 8'd13, 8'd11, 5'd7);
    step();
    offer(OP_ADD, 8'd1, 8'd1, 5'd9);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL mul_busy_ready cycle %0d: got %b want %b", n, in_ready, 1'b0);
      end
      step();
      n++;
    end
    n_cmp++;
    if (n !== 8) begin
      n_bad++; $display("FAIL mul_latency: got %0d want %0d", n, 8);
    end
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h8F, 4'b0100, 5'd7}) begin
      n_bad++; $display("FAIL mul_result: got %h want %h", obs, {1'b1, 8'h8F, 4'b0100, 5'd7});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mul_idle_ready: got %b want %b", in_ready, 1'b1);
    end
    step();
    in_valid = 1'b0;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h02, 4'b0000, 5'd9}) begin
      n_bad++; $display("FAIL mul_followup: got %h want %h", obs, {1'b1, 8'h02, 4'b0000, 5'd9});
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [17:0] obs;
    out_ready = 1'b0;
    offer(OP_ADD, 8'h01, 8'h02, 5'd1);
    step();
    offer(OP_XOR, 8'hF0, 8'h3C, 5'd2);
    for (int i = 0; i < 3; i++) begin
      obs = {out_valid, result, flags, out_tag};
      n_cmp++;
      if (obs !== {1'b1, 8'h03, 4'b0000, 5'd1} || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got %h ready %b want %h ready 0", i, obs, in_ready,
                 {1'b1, 8'h03, 4'b0000, 5'd1});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release_ready: got %b want %b", in_ready, 1'b1);
    end
    step();
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'hCC, 4'b0100, 5'd2}) begin
      n_bad++; $display("FAIL bp_second: got %h want %h", obs, {1'b1, 8'hCC, 4'b0100, 5'd2});
    end
    offer(OP_OR, 8'h01, 8'h02, 5'd3);
    step();
    in_valid = 1'b0;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h03, 4'b0000, 5'd3}) begin
      n_bad++; $display("FAIL bp_third: got %h want %h", obs, {1'b1, 8'h03, 4'b0000, 5'd3});
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_empty: got %b want %b", out_valid, 1'b0);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [17:0] obs;
    offer(OP_MUL, 8'd13, 8'd11, 5'd4);
    step();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== 18'h0) begin
      n_bad++; $display("FAIL midmul_reset: got %h want %h", obs, 18'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL midmul_discard: got %b want %b", {out_valid, in_ready}, 2'b01);
    end
    offer(OP_ADD, 8'd2, 8'd3, 5'd6);
    step();
    in_valid = 1'b0;
    obs = {out_valid, result, flags, out_tag};
    n_cmp++;
    if (obs !== {1'b1, 8'h05, 4'b0000, 5'd6}) begin
      n_bad++; $display("FAIL post_reset_add: got %h want %h", obs, {1'b1, 8'h05, 4'b0000, 5'd6});
    end
    step();
  endtask

  task automatic test_ops_table();
    logic [3:0] t_op  [9] = '{4'hE, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_AND, OP_PASSB, OP_SUB, OP_ADD};
    logic [7:0] t_a   [9] = '{8'h55, 8'hFF, 8'hFF, 8'h81, 8'h81, 8'hC3, 8'h00, 8'h01, 8'h7F};
    logic [7:0] t_b   [9] = '{8'h00, 8'h01, 8'h01, 8'h0B, 8'h03, 8'h5A, 8'hA5, 8'h02, 8'h01};
    logic [7:0] t_res [9] = '{8'h00, 8'h01, 8'h00, 8'h08, 8'h10, 8'h42, 8'hA5, 8'hFF, 8'h80};
    logic [3:0] t_flg [9] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                              4'b0110, 4'b0101};
    logic [17:0] obs;
    logic [17:0] exp_v;
    for (int i = 0; i < 9; i++) begin
      offer(t_op[i], t_a[i], t_b[i], 5'(i + 10));
      step();
      obs   = {out_valid, result, flags, out_tag};
      exp_v = {1'b1, t_res[i], t_flg[i], 5'(i + 10)};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL op_table[%0d] op=%h: got %h want %h", i, t_op[i], obs, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sra();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_ops_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
